d_e_queue: RTL and testbench

- Parametrised elastic decode-to-execute stage that replaces the single stall-gated D/E register with a DEPTH-entry in-order FIFO.
- Uses a valid/ready handshake on both sides, a pipeline flush and an occupancy output.
- Decode pushes decoded instructions (operands, immediate, ROB id). Execute pops them in program order.
- Bubbles are never stored.

---
 rtl/d_e_queue_pkg.sv | 56 +++++
 rtl/d_e_queue_fifo_ptr_ctrl.sv | 78 +++++++
 rtl/d_e_queue.sv | 124 ++++++++++++
 tb/tb_d_e_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_e_queue_pkg.sv
// ---------------------------------------------------------------------------
// d_e_queue_pkg
// Shared definitions for the decode-to-execute queue: datapath widths,
// RISC-V opcode / funct constants, instruction classes and the packed
// payload record carried from decode to execute.
// ---------------------------------------------------------------------------
package d_e_queue_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int INSTR_TYPE_SZ   = 3;
  localparam int ROB_ENTRY_WIDTH = 4;

  // Major opcodes (RV32I)
  localparam logic [6:0] OPCODE_ALU    = 7'b0110011;
  localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  // funct3 / funct7 encodings used by execute
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [INSTR_TYPE_SZ-1:0] {
    ITYPE_R      = 3'd0,
    ITYPE_I      = 3'd1,
    ITYPE_S      = 3'd2,
    ITYPE_B      = 3'd3,
    ITYPE_U      = 3'd4,
    ITYPE_J      = 3'd5
  } instr_type_e;

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic [6:0]                 opcode;
    logic [6:0]                 funct7;
    logic [2:0]                 funct3;
    logic [WORD_SIZE-1:0]       s1;
    logic [WORD_SIZE-1:0]       s2;
    logic [WORD_SIZE-1:0]       immediate;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
  } d_e_payload_t;

  localparam int PAYLOAD_W = $bits(d_e_payload_t);

endpackage

// File: rtl/d_e_queue_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
// Pointer / occupancy controller for a DEPTH-entry in-order FIFO.
// Ports:
//   clk, reset (sync, active-low), flush (drop all entries)
//   push_req / pop_req   : producer valid and consumer ready
//   push_fire / pop_fire : qualified handshakes actually taken this cycle
//   wr_ptr / rd_ptr      : storage write / read index
//   count                : number of valid entries
//   in_ready / out_valid : derived purely from the registered count
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic                       pop_req,
  output logic                       push_fire,
  output logic                       pop_fire,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       in_ready,
  output logic                       out_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  // Full/empty come from the count, never from pointer equality, so a full
  // queue cannot accept a push even when a pop happens in the same cycle.
  assign in_ready  = (count_r != CNT_W'(DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});

  // A flush discards any handshake occurring in the same cycle.
  assign push_fire = push_req & in_ready  & ~flush;
  assign pop_fire  = pop_req  & out_valid & ~flush;

  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;

  // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_comb begin
    count_next_s = count_r;
    case ({push_fire, pop_fire})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; reset dominates flush, flush dominates traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_fire) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_fire)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/d_e_queue.sv
// ---------------------------------------------------------------------------
// d_e_queue
// Elastic decode-to-execute stage: a DEPTH-entry in-order FIFO of decoded
// instructions with valid/ready on both sides, flush and occupancy output.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid / in_ready   : decode-side handshake
//   instruction_type, pc, opcode, funct7, funct3, s1, s2, immediate, rob_id
//                         : decoded payload
//   flush                 : drop all queued instructions
//   out_valid / out_ready : execute-side handshake
//   *_out                 : head-entry payload, zero when out_valid=0
//   count                 : number of queued instructions
// WORD_SIZE / INSTR_TYPE_SZ / ROB_ENTRY_WIDTH must match the package,
// since entries are stored as d_e_payload_t.
// ---------------------------------------------------------------------------
module d_e_queue
  import d_e_queue_pkg::*;
#(
  parameter int WORD_SIZE       = d_e_queue_pkg::WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = d_e_queue_pkg::INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = d_e_queue_pkg::ROB_ENTRY_WIDTH,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [6:0]                 opcode,
  input  logic [6:0]                 funct7,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       s1,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [WORD_SIZE-1:0]       immediate,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic [6:0]                 opcode_out,
  output logic [6:0]                 funct7_out,
  output logic [2:0]                 funct3_out,
  output logic [WORD_SIZE-1:0]       s1_out,
  output logic [WORD_SIZE-1:0]       s2_out,
  output logic [WORD_SIZE-1:0]       immediate_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  d_e_payload_t              mem_r [DEPTH];
  d_e_payload_t              in_payload_s;
  d_e_payload_t              head_s;
  logic                      push_fire_s;
  logic                      pop_fire_s;
  logic                      out_valid_s;
  logic [PTR_W-1:0]          wr_ptr_s;
  logic [PTR_W-1:0]          rd_ptr_s;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push_req  (in_valid),
    .pop_req   (out_ready),
    .push_fire (push_fire_s),
    .pop_fire  (pop_fire_s),
    .wr_ptr    (wr_ptr_s),
    .rd_ptr    (rd_ptr_s),
    .count     (count),
    .in_ready  (in_ready),
    .out_valid (out_valid_s)
  );

  assign in_payload_s.instruction_type = instruction_type;
  assign in_payload_s.pc               = pc;
  assign in_payload_s.opcode           = opcode;
  assign in_payload_s.funct7           = funct7;
  assign in_payload_s.funct3           = funct3;
  assign in_payload_s.s1               = s1;
  assign in_payload_s.s2               = s2;
  assign in_payload_s.immediate        = immediate;
  assign in_payload_s.rob_id           = rob_id;

  // Entry storage; deliberately not cleared on reset or flush because the
  // output gating below already hides stale contents.
  always_ff @(posedge clk) begin
    if (reset && push_fire_s) begin
      mem_r[wr_ptr_s] <= in_payload_s;
    end
  end

  // Head-of-queue select, forced to zero while the queue is empty.
  always_comb begin
    head_s = {PAYLOAD_W{1'b0}};
    if (out_valid_s) begin
      head_s = mem_r[rd_ptr_s];
    end else begin
      head_s = {PAYLOAD_W{1'b0}};
    end
  end

  assign out_valid            = out_valid_s;
  assign instruction_type_out = head_s.instruction_type;
  assign pc_out               = head_s.pc;
  assign opcode_out           = head_s.opcode;
  assign funct7_out           = head_s.funct7;
  assign funct3_out           = head_s.funct3;
  assign s1_out               = head_s.s1;
  assign s2_out               = head_s.s2;
  assign immediate_out        = head_s.immediate;
  assign rob_id_out           = head_s.rob_id;

  // pop_fire_s is consumed inside the controller; kept visible for debug.
  logic unused_s;
  assign unused_s = pop_fire_s;

endmodule

// File: tb/tb_d_e_queue.sv
// ---------------------------------------------------------------------------
// tb_d_e_queue
// Directed bench for d_e_queue (DEPTH=4) with a queue-based reference:
// accepted pushes are appended to sb, predicted pops are compared against
// its front, and status outputs are compared against the reference size.
// ---------------------------------------------------------------------------
module tb_d_e_queue;
  import d_e_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                       clk;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [INSTR_TYPE_SZ-1:0]   instruction_type;
  logic [WORD_SIZE-1:0]       pc;
  logic [6:0]                 opcode;
  logic [6:0]                 funct7;
  logic [2:0]                 funct3;
  logic [WORD_SIZE-1:0]       s1;
  logic [WORD_SIZE-1:0]       s2;
  logic [WORD_SIZE-1:0]       immediate;
  logic [ROB_ENTRY_WIDTH-1:0] rob_id;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [INSTR_TYPE_SZ-1:0]   instruction_type_out;
  logic [WORD_SIZE-1:0]       pc_out;
  logic [6:0]                 opcode_out;
  logic [6:0]                 funct7_out;
  logic [2:0]                 funct3_out;
  logic [WORD_SIZE-1:0]       s1_out;
  logic [WORD_SIZE-1:0]       s2_out;
  logic [WORD_SIZE-1:0]       immediate_out;
  logic [ROB_ENTRY_WIDTH-1:0] rob_id_out;
  logic [CNT_W-1:0]           count;

  int checks = 0;
  int errors = 0;
  d_e_payload_t sb[$];

  d_e_queue #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .instruction_type     (instruction_type),
    .pc                   (pc),
    .opcode               (opcode),
    .funct7               (funct7),
    .funct3               (funct3),
    .s1                   (s1),
    .s2                   (s2),
    .immediate            (immediate),
    .rob_id               (rob_id),
    .flush                (flush),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .instruction_type_out (instruction_type_out),
    .pc_out               (pc_out),
    .opcode_out           (opcode_out),
    .funct7_out           (funct7_out),
    .funct3_out           (funct3_out),
    .s1_out               (s1_out),
    .s2_out               (s2_out),
    .immediate_out        (immediate_out),
    .rob_id_out           (rob_id_out),
    .count                (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic d_e_payload_t mk(input int r);
    d_e_payload_t p;
    p.instruction_type = INSTR_TYPE_SZ'(r);
    p.pc               = 32'h0000_1000 + 32'(r) * 32'd4;
    p.opcode           = (r % 2 == 1) ? OPCODE_ALUI : OPCODE_ALU;
    p.funct7           = 7'(r * 5);
    p.funct3           = 3'(r);
    p.s1               = 32'(r * 17 + 1);
    p.s2               = ~32'(r);
    p.immediate        = 32'(r) << 8;
    p.rob_id           = ROB_ENTRY_WIDTH'(r);
    return p;
  endfunction

  function automatic d_e_payload_t head_obs();
    d_e_payload_t p;
    p.instruction_type = instruction_type_out;
    p.pc               = pc_out;
    p.opcode           = opcode_out;
    p.funct7           = funct7_out;
    p.funct3           = funct3_out;
    p.s1               = s1_out;
    p.s2               = s2_out;
    p.immediate        = immediate_out;
    p.rob_id           = rob_id_out;
    return p;
  endfunction

  task automatic check(input string tag, input logic [PAYLOAD_W-1:0] obs,
                       input logic [PAYLOAD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input d_e_payload_t p, input logic ordy, input logic fl);
    in_valid         = iv;
    instruction_type = p.instruction_type;
    pc               = p.pc;
    opcode           = p.opcode;
    funct7           = p.funct7;
    funct3           = p.funct3;
    s1               = p.s1;
    s2               = p.s2;
    immediate        = p.immediate;
    rob_id           = p.rob_id;
    out_ready        = ordy;
    flush            = fl;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"},     PAYLOAD_W'(count),     PAYLOAD_W'(sb.size()));
    check({tag, ".out_valid"}, PAYLOAD_W'(out_valid), PAYLOAD_W'(sb.size() != 0));
    check({tag, ".in_ready"},  PAYLOAD_W'(in_ready),  PAYLOAD_W'(sb.size() != DEPTH));
    if (sb.size() != 0) check({tag, ".head"}, head_obs(), sb[0]);
    else                check({tag, ".head_zero"}, head_obs(), {PAYLOAD_W{1'b0}});
  endtask

  // One clock with reset released: predicts handshakes from the reference.
  task automatic cycle(input string tag, input logic iv, input d_e_payload_t p,
                       input logic ordy, input logic fl);
    bit push_ok;
    bit pop_ok;
    reset = 1'b1;
    drive(iv, p, ordy, fl);
    #1;
    push_ok = iv && (sb.size() < DEPTH);
    pop_ok  = ordy && (sb.size() > 0);
    if (pop_ok) check({tag, ".pop"}, head_obs(), sb[0]);
    @(posedge clk); #1;
    if (fl) sb.delete();
    else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(p);
    end
    check_status(tag);
  endtask

  task automatic reset_cycles(input int n, input logic fl);
    reset = 1'b0;
    drive(1'b1, mk(9), 1'b1, fl);
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    check_status("reset");
  endtask

  initial begin
    d_e_payload_t p;
    int r;

    // Reset held for two cycles while decode offers an instruction
    drive(1'b1, mk(9), 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset_cycles(2, 1'b0);
    reset = 1'b1;
    drive(1'b0, mk(0), 1'b0, 1'b0);
    #1;
    check("in_ready_after_reset", PAYLOAD_W'(in_ready), PAYLOAD_W'(1));
    cycle("idle", 1'b0, mk(0), 1'b0, 1'b0);

    // Single pass with the documented payload
    p = mk(2);
    p.opcode = OPCODE_ALU; p.s1 = 32'd23; p.s2 = 32'd7; p.immediate = 32'd89; p.rob_id = 4'd2;
    cycle("single_push", 1'b1, p, 1'b0, 1'b0);
    check("single_s1",  PAYLOAD_W'(s1_out), PAYLOAD_W'(32'd23));
    check("single_rob", PAYLOAD_W'(rob_id_out), PAYLOAD_W'(4'd2));
    cycle("single_pop", 1'b0, mk(0), 1'b1, 1'b0);
    check("single_empty", PAYLOAD_W'(count), PAYLOAD_W'(0));

    // Fill with backpressure: fifth push must be dropped
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, mk(i), 1'b0, 1'b0);
    check("fill_full", PAYLOAD_W'(count), PAYLOAD_W'(DEPTH));
    for (int i = 0; i < 4; i++) begin
      check("drain_order", PAYLOAD_W'(rob_id_out), PAYLOAD_W'(i));
      cycle("drain", 1'b0, mk(0), 1'b1, 1'b0);
    end

    // Concurrent push/pop at count=2, pointers wrap
    r = 20;
    cycle("pre", 1'b1, mk(r), 1'b0, 1'b0); r++;
    cycle("pre", 1'b1, mk(r), 1'b0, 1'b0); r++;
    for (int i = 0; i < 8; i++) begin
      cycle("concurrent", 1'b1, mk(r), 1'b1, 1'b0); r++;
      check("concurrent_count", PAYLOAD_W'(count), PAYLOAD_W'(2));
    end

    // Full plus pop: pop taken, push refused
    cycle("refill", 1'b1, mk(r), 1'b0, 1'b0); r++;
    cycle("refill", 1'b1, mk(r), 1'b0, 1'b0); r++;
    cycle("full_pop", 1'b1, mk(r), 1'b1, 1'b0); r++;
    check("full_pop_count", PAYLOAD_W'(count), PAYLOAD_W'(3));

    // Flush beats push and pop in the same cycle
    cycle("flush", 1'b1, mk(r), 1'b1, 1'b1); r++;
    check("flush_count", PAYLOAD_W'(count), PAYLOAD_W'(0));
    cycle("post_flush", 1'b1, mk(r), 1'b0, 1'b0); r++;
    cycle("post_flush", 1'b1, mk(r), 1'b0, 1'b0); r++;
    cycle("post_flush_pop", 1'b0, mk(0), 1'b1, 1'b0);

    // Reset together with flush and traffic
    reset_cycles(1, 1'b1);
    reset = 1'b1;
    cycle("after_reset", 1'b1, mk(40), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
